// File: rtl/rf_pkg.sv
// Shared types and constants for the scoreboarded register file.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding).
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Hardwired zero register index.
  localparam int ZERO_ADDR = 0;

  typedef logic [ADDR_W_DEF-1:0] rf_addr_t;
  typedef logic [DATA_W_DEF-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: selects the stored word, forces the zero
// register, optionally forwards the same-cycle writeback and reports busy.
// Optional feature macro: RF_BYPASS_EN.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  localparam int NREG    = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [NREG*DATA_W-1:0] i_regs,
  input  logic [NREG-1:0]        i_pend,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [DATA_W-1:0]      i_wr_data,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_busy
);

  logic isZero;
  logic bypassHit;

  assign isZero = (ZERO_REG != 0) && (i_addr == ADDR_W'(ZERO_ADDR));

`ifdef RF_BYPASS_EN
  assign bypassHit = i_wr_en && (i_wr_addr == i_addr) && !isZero;
`else
  logic unusedBypass;
  assign unusedBypass = ^{i_wr_en, i_wr_addr, i_wr_data};
  assign bypassHit    = 1'b0;
`endif

  // Data mux: zero register wins, then forwarded writeback, then storage.
  always_comb begin
    o_data = i_regs[i_addr*DATA_W +: DATA_W];
    if (isZero) begin
      o_data = '0;
    end else if (bypassHit) begin
`ifdef RF_BYPASS_EN
      o_data = i_wr_data;
`endif
    end
  end

  // Busy: an outstanding producer, unless it is retiring through the bypass now.
  always_comb begin
    o_busy = i_pend[i_addr] && !isZero && !bypassHit;
  end

endmodule

// File: rtl/rf_scoreboard.sv
// 2-read/1-write register file with a per-register pending bit used by the
// in-order pipeline: issue marks a destination pending, writeback clears it.
// Optional feature macro: RF_BYPASS_EN (forwarding, busy masking and
// WAW acceptance when the pending register retires in the same cycle).
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  localparam int NREG    = 2 ** ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic [DATA_W-1:0] o_rd_data1,
  output logic [DATA_W-1:0] o_rd_data2,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic              o_stall,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_iss_en,
  input  logic [ADDR_W-1:0] i_iss_addr,
  output logic              o_iss_rej,
  output logic [ADDR_W:0]   o_pend_cnt
);

  logic [DATA_W-1:0]      regs_q [NREG];
  logic [NREG*DATA_W-1:0] regFlat;
  logic [NREG-1:0]        pend_q, pend_d;
  logic [NREG-1:0]        clrVec, setVec;
  logic [ADDR_W:0]        cnt_q, cnt_d;
  logic                   wrLive;
  logic                   issZero;
  logic                   issRej;
  logic                   cntInc, cntDec;

  assign wrLive  = i_wr_en && !((ZERO_REG != 0) && (i_wr_addr == ADDR_W'(ZERO_ADDR)));
  assign issZero = (ZERO_REG != 0) && (i_iss_addr == ADDR_W'(ZERO_ADDR));

  // Register storage; the zero register is never written when hardwired.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (wrLive) begin
      regs_q[i_wr_addr] <= i_wr_data;
    end
  end

  // Flatten storage so each read port sees a plain vector.
  always_comb begin
    regFlat = '0;
    for (int r = 0; r < NREG; r++) regFlat[r*DATA_W +: DATA_W] = regs_q[r];
  end

  // Clear vector from writeback; issue rejection on an unretired producer.
  always_comb begin
    clrVec = '0;
    if (wrLive) clrVec[i_wr_addr] = 1'b1;
`ifdef RF_BYPASS_EN
    issRej = i_iss_en && pend_q[i_iss_addr] && !clrVec[i_iss_addr];
`else
    issRej = i_iss_en && pend_q[i_iss_addr];
`endif
  end

  // Next pending state: a new producer wins over a same-cycle clear.
  always_comb begin
    setVec = '0;
    if (i_iss_en && !issRej && !issZero) setVec[i_iss_addr] = 1'b1;
    pend_d = (pend_q & ~clrVec) | setVec;
  end

  // Count tracks popcount: +1 for a fresh set, -1 for a real clear.
  always_comb begin
    cntInc = |(setVec & ~pend_q);
    cntDec = |(clrVec & pend_q & ~setVec);
    cnt_d  = cnt_q;
    case ({cntInc, cntDec})
      2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Scoreboard bits and pending counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) uPort1 (
    .i_addr   (i_rd_addr1),
    .i_regs   (regFlat),
    .i_pend   (pend_q),
    .i_wr_en  (i_wr_en),
    .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data),
    .o_data   (o_rd_data1),
    .o_busy   (o_busy1)
  );

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) uPort2 (
    .i_addr   (i_rd_addr2),
    .i_regs   (regFlat),
    .i_pend   (pend_q),
    .i_wr_en  (i_wr_en),
    .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data),
    .o_data   (o_rd_data2),
    .o_busy   (o_busy2)
  );

  assign o_stall    = o_busy1 | o_busy2;
  assign o_iss_rej  = issRej;
  assign o_pend_cnt = cnt_q;

endmodule
